// File: rtl/sobel_pkg.sv
// sobel_pkg: pixel width, default image geometry and stream FSM states shared by the Sobel output stage.
package sobel_pkg;
  localparam int PIX_W = 8;
  localparam int IMG_X_DEF = 100;
  localparam int IMG_Y_DEF = 100;
  localparam int FRAME_PIX_DEF = IMG_X_DEF * IMG_Y_DEF;
  typedef enum logic {IDLE, STREAM} state_e;
endpackage

// File: rtl/sobel_px_fifo.sv
// sobel_px_fifo: synchronous show-ahead pixel FIFO with occupancy count; clr_i flushes it like a reset.
module sobel_px_fifo import sobel_pkg::*; #(
  parameter int DEPTH = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       clr_i,
  input  logic                       wr_i,
  input  logic [PIX_W-1:0]           wr_data_i,
  input  logic                       rd_i,
  output logic [PIX_W-1:0]           rd_data_o,
  output logic [$clog2(DEPTH+1)-1:0] fill_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int FW = $clog2(DEPTH+1);
  logic [PIX_W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FW-1:0] fill_q, fill_d;
  assign fill_d = fill_q + FW'(wr_i) - FW'(rd_i);
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q <= '0;
    end else begin
      if (wr_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_i) rd_ptr_q <= rd_ptr_q + 1'b1;
      fill_q <= fill_d;
    end
  end
  // When full, a same-cycle read frees the slot the write lands in.
  always_ff @(posedge clk_i)
    if (wr_i) mem_q[wr_ptr_q] <= wr_data_i;
  assign rd_data_o = mem_q[rd_ptr_q];
  assign fill_o = fill_q;
endmodule

// File: rtl/sobel_avst_source.sv
// sobel_avst_source: buffers edge-detected pixels and emits them as an Avalon-ST source with sop/eop framing.
// Define SOBEL_AVST_THRESHOLD_EN to binarise pixels against THRESHOLD before buffering.
module sobel_avst_source import sobel_pkg::*; #(
  parameter int IMG_X_SIZE = IMG_X_DEF,
  parameter int IMG_Y_SIZE = IMG_Y_DEF,
  parameter int FIFO_DEPTH = 16,
  parameter int THRESHOLD = 128
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            start_i,
  input  logic [PIX_W-1:0]                pixel_i,
  input  logic                            pixel_valid_i,
  output logic [PIX_W-1:0]                src_data_o,
  output logic                            src_valid_o,
  input  logic                            src_ready_i,
  output logic                            src_sop_o,
  output logic                            src_eop_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fill_o,
  output logic                            overflow_o,
  output logic                            busy_o,
  output logic                            frame_done_o
);
  localparam int N = IMG_X_SIZE * IMG_Y_SIZE;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  localparam int FW = $clog2(FIFO_DEPTH+1);
`ifdef SOBEL_AVST_THRESHOLD_EN
  localparam bit TH_EN = 1'b1;
`else
  localparam bit TH_EN = 1'b0;
`endif
  logic [CW-1:0] cnt_q, cnt_d;
  state_e state_q, state_d;
  logic ovf_q, done_q;
  logic [FW-1:0] fill;
  logic [PIX_W-1:0] head, wr_data;
  logic full, xfer, wr, last;
  assign full = fill == FW'(FIFO_DEPTH);
  assign src_valid_o = fill != '0;
  assign xfer = src_valid_o && src_ready_i;
  assign wr = pixel_valid_i && !start_i && (!full || xfer);
  assign last = cnt_q == CW'(N-1);
  assign wr_data = TH_EN ? ((pixel_i >= PIX_W'(THRESHOLD)) ? {PIX_W{1'b1}} : {PIX_W{1'b0}}) : pixel_i;
  sobel_px_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .clr_i(start_i),
    .wr_i(wr),
    .wr_data_i(wr_data),
    .rd_i(xfer),
    .rd_data_o(head),
    .fill_o(fill)
  );
  always_comb begin
    cnt_d = xfer ? (last ? '0 : cnt_q + 1'b1) : cnt_q;
    state_d = (state_q == IDLE) ? (wr ? STREAM : IDLE) : ((xfer && last && !wr) ? IDLE : STREAM);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i || start_i) begin
      cnt_q <= '0;
      state_q <= IDLE;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      state_q <= state_d;
      ovf_q <= ovf_q | (pixel_valid_i && full && !xfer);
    end
  end
  // The sink still completes an eop transfer coinciding with start, so the pulse is kept.
  always_ff @(posedge clk_i)
    done_q <= rst_i ? 1'b0 : (xfer && last);
  assign src_data_o = src_valid_o ? head : '0;
  assign src_sop_o = src_valid_o && cnt_q == '0;
  assign src_eop_o = src_valid_o && last;
  assign fill_o = fill;
  assign overflow_o = ovf_q;
  assign busy_o = state_q == STREAM;
  assign frame_done_o = done_q;
endmodule

// File: tb/tb_sobel_avst_source.sv
// tb_sobel_avst_source: directed bench for a 4x4-frame, 4-deep sobel_avst_source.
module tb_sobel_avst_source;
  logic clk, rst, start, pixel_valid, ready;
  logic [7:0] pixel, data;
  logic valid, sop, eop, ovf, busy, done;
  logic [2:0] fill;
  int checks = 0, failures = 0, done_cnt = 0, stall_viol = 0;
  logic [7:0] q_data[$];
  bit q_sop[$], q_eop[$];
  bit stalled = 0;
  logic [9:0] stall_snap = '0;

  sobel_avst_source #(.IMG_X_SIZE(4), .IMG_Y_SIZE(4), .FIFO_DEPTH(4), .THRESHOLD(128)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .pixel_i(pixel), .pixel_valid_i(pixel_valid),
    .src_data_o(data), .src_valid_o(valid), .src_ready_i(ready), .src_sop_o(sop), .src_eop_o(eop),
    .fill_o(fill), .overflow_o(ovf), .busy_o(busy), .frame_done_o(done)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst && valid && ready) begin
      q_data.push_back(data);
      q_sop.push_back(sop);
      q_eop.push_back(eop);
    end
    if (done) done_cnt++;
    if (stalled && valid && !rst && !start && {data, sop, eop} != stall_snap) stall_viol++;
    stalled = valid && !ready && !rst && !start;
    stall_snap = {data, sop, eop};
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int qd(input int idx);
    return idx < q_data.size() ? int'(q_data[idx]) : -1;
  endfunction

  task automatic check_frame(input string tag, input int base, input int first);
    chk({tag, "_count"}, q_data.size() - base, 16);
    for (int j = 0; j < 16; j++) begin
      chk($sformatf("%s_data%0d", tag, j), qd(base + j), first + j);
      chk($sformatf("%s_sop%0d", tag, j), base + j < q_sop.size() ? int'(q_sop[base + j]) : -1, j == 0 ? 1 : 0);
      chk($sformatf("%s_eop%0d", tag, j), base + j < q_eop.size() ? int'(q_eop[base + j]) : -1, j == 15 ? 1 : 0);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_valid"}, int'(valid), 0);
    chk({tag, "_sop"}, int'(sop), 0);
    chk({tag, "_eop"}, int'(eop), 0);
    chk({tag, "_data"}, int'(data), 0);
    chk({tag, "_fill"}, int'(fill), 0);
    chk({tag, "_ovf"}, int'(ovf), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
  endtask

  initial begin
    int base, dbase;
    logic [7:0] th_in [3];
    logic [7:0] th_exp [3];
    rst = 1; start = 0; pixel_valid = 0; pixel = 0; ready = 0;
    cyc(2);
    rst = 0;
    check_reset("reset");

    // back-to-back frame 0..15 with ready held high
    ready = 1;
    base = q_data.size();
    dbase = done_cnt;
    for (int i = 0; i < 16; i++) begin
      pixel_valid = 1; pixel = 8'(i);
      cyc();
      if (i == 0) begin
        chk("lat_valid", int'(valid), 1);
        chk("lat_data", int'(data), 0);
        chk("lat_sop", int'(sop), 1);
        chk("lat_busy", int'(busy), 1);
      end
    end
    pixel_valid = 0;
    cyc(4);
    check_frame("f1", base, 0);
    chk("f1_done", done_cnt - dbase, 1);
    chk("f1_ovf", int'(ovf), 0);
    chk("f1_busy_end", int'(busy), 0);

    // overflow: 6 writes into a 4-deep buffer while stalled
    ready = 0;
    for (int i = 0; i < 6; i++) begin
      pixel_valid = 1; pixel = 8'(100 + i);
      cyc();
    end
    pixel_valid = 0;
    chk("ovf_fill", int'(fill), 4);
    chk("ovf_flag", int'(ovf), 1);
    chk("ovf_head", int'(data), 100);
    base = q_data.size();
    ready = 1;
    cyc(6);
    chk("ovf_xfers", q_data.size() - base, 4);
    for (int j = 0; j < 4; j++) chk($sformatf("ovf_data%0d", j), qd(base + j), 100 + j);
    chk("ovf_sticky", int'(ovf), 1);
    start = 1;
    cyc();
    start = 0;
    chk("start_ovf", int'(ovf), 0);
    chk("start_busy", int'(busy), 0);

    // full buffer with simultaneous write and transfer
    ready = 0;
    for (int i = 0; i < 4; i++) begin
      pixel_valid = 1; pixel = 8'(20 + i);
      cyc();
    end
    chk("full_fill", int'(fill), 4);
    base = q_data.size();
    ready = 1; pixel_valid = 1; pixel = 8'd24;
    cyc();
    pixel_valid = 0;
    chk("simul_fill", int'(fill), 4);
    chk("simul_ovf", int'(ovf), 0);
    chk("simul_head", int'(data), 21);
    cyc(6);
    chk("simul_xfers", q_data.size() - base, 5);
    for (int j = 0; j < 5; j++) chk($sformatf("simul_data%0d", j), qd(base + j), 20 + j);
    start = 1;
    cyc();
    start = 0;

    // ready toggling every cycle, one pixel every other cycle
    base = q_data.size();
    dbase = done_cnt;
    for (int i = 0; i < 32; i++) begin
      ready = i[0];
      pixel_valid = !i[0];
      pixel = 8'(50 + i / 2);
      cyc();
    end
    ready = 1; pixel_valid = 0;
    cyc(8);
    check_frame("tog", base, 50);
    chk("tog_done", done_cnt - dbase, 1);
    chk("tog_ovf", int'(ovf), 0);
    chk("tog_stall", stall_viol, 0);

    // reset mid-frame after 7 pixels
    for (int i = 0; i < 7; i++) begin
      pixel_valid = 1; pixel = 8'(70 + i);
      cyc();
    end
    pixel_valid = 0; rst = 1;
    cyc();
    rst = 0;
    check_reset("midrst");
    base = q_data.size();
    dbase = done_cnt;
    for (int i = 0; i < 16; i++) begin
      pixel_valid = 1; pixel = 8'(80 + i);
      cyc();
    end
    pixel_valid = 0;
    cyc(4);
    check_frame("rst_f", base, 80);
    chk("rst_done", done_cnt - dbase, 1);

    // threshold build binarises, default build passes through
    th_in[0] = 8'd127; th_in[1] = 8'd128; th_in[2] = 8'd255;
`ifdef SOBEL_AVST_THRESHOLD_EN
    th_exp[0] = 8'h00; th_exp[1] = 8'hFF; th_exp[2] = 8'hFF;
`else
    th_exp[0] = 8'd127; th_exp[1] = 8'd128; th_exp[2] = 8'd255;
`endif
    base = q_data.size();
    for (int i = 0; i < 3; i++) begin
      pixel_valid = 1; pixel = th_in[i];
      cyc();
    end
    pixel_valid = 0;
    cyc(4);
    chk("th_xfers", q_data.size() - base, 3);
    for (int j = 0; j < 3; j++) chk($sformatf("th_data%0d", j), qd(base + j), int'(th_exp[j]));
    chk("th_sop", base < q_sop.size() ? int'(q_sop[base]) : -1, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sobel_avst_source.md
SOBEL_AVST_SOURCE -- requirements
Module: sobel_avst_source

Interface
REQ-001 SHALL have parameter IMG_X_SIZE, default 100, frame width in pixels.
REQ-002 SHALL have parameter IMG_Y_SIZE, default 100, frame height in pixels.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, buffer entries, power of two, at least 2.
REQ-004 SHALL have parameter THRESHOLD, default 128, binarisation level, used only under REQ-027.
REQ-005 SHALL have ports: clk_i in 1, the single clock; rst_i in 1, reset, synchronous and active-high.
REQ-006 SHALL have ports: start_i in 1, frame start (flush); pixel_i in 8, processed pixel from the edge-detection stage; pixel_valid_i in 1, pixel_i qualifier.
REQ-007 SHALL have ports: src_data_o out 8; src_valid_o out 1; src_ready_i in 1; src_sop_o out 1; src_eop_o out 1. Together these form the Avalon-ST source, readyLatency 0.
REQ-008 SHALL have ports: fill_o out $clog2(FIFO_DEPTH+1), buffer occupancy; overflow_o out 1, sticky drop flag; busy_o out 1, frame in progress; frame_done_o out 1, end-of-frame pulse.

Function
REQ-009 SHALL accept pixel_i on a rising edge when pixel_valid_i=1 and either fill<FIFO_DEPTH or an output transfer occurs in the same cycle.
REQ-010 SHALL drop a pixel presented while full with no same-cycle transfer, and SHALL set overflow_o=1 on the next edge.
REQ-011 SHALL hold overflow_o high until rst_i or start_i.
REQ-012 SHALL treat a transfer as src_valid_o=1 and src_ready_i=1 on a rising edge.
REQ-013 SHALL drive src_valid_o=1 exactly when fill>0, with src_data_o equal to the oldest entry (show-ahead).
REQ-014 SHALL keep src_data_o, src_sop_o and src_eop_o stable while src_valid_o=1 and src_ready_i=0.
REQ-015 SHALL produce a latency of 1: a pixel accepted into an empty buffer at edge k appears on src_valid_o/src_data_o after edge k.
REQ-016 SHALL leave fill unchanged when a write and a transfer occur in the same cycle, including when full or empty-plus-write.
REQ-017 SHALL keep an output pixel counter of width $clog2(IMG_X_SIZE*IMG_Y_SIZE), advancing only on a transfer.
REQ-018 SHALL drive src_sop_o=1 when the counter is 0, and src_eop_o=1 when the counter is IMG_X_SIZE*IMG_Y_SIZE-1; both are qualified by src_valid_o.
REQ-019 SHALL wrap the counter to 0 on the eop transfer and SHALL pulse frame_done_o high for exactly one cycle after that edge.
REQ-020 SHALL use FSM states IDLE and STREAM: IDLE->STREAM on the first accepted pixel; STREAM->IDLE on the eop transfer, unless a pixel is accepted in the same cycle, in which case it stays in STREAM; busy_o=1 in STREAM.
REQ-021 SHALL, on start_i=1, clear the buffer, fill, counter and overflow_o and enter IDLE on the next edge.
REQ-022 SHALL give start_i priority over a same-cycle write or transfer: the write is discarded and the transfer is still considered completed by the sink.
REQ-023 SHALL pass through without ever dropping data when pixels arrive at most once per cycle and src_ready_i is held at 1.

Reset
REQ-024 SHALL, on rst_i=1 at a rising edge, set src_valid_o=0, src_sop_o=0, src_eop_o=0, src_data_o=0, fill_o=0, overflow_o=0, busy_o=0 and frame_done_o=0, with the FSM in IDLE and the counter at 0.
REQ-025 SHALL discard all buffered pixels on reset mid-frame; the next frame starts with sop.
REQ-026 SHALL give rst_i priority over start_i and all other inputs.

Configuration
REQ-027 SHALL, with SOBEL_AVST_THRESHOLD_EN defined, store 8'hFF when pixel_i>=THRESHOLD and 8'h00 otherwise.
REQ-028 SHALL, without SOBEL_AVST_THRESHOLD_EN, store pixel_i unmodified and ignore THRESHOLD.
REQ-029 SHALL keep timing, latency and flags identical in both builds.

Structure
REQ-030 SHALL place the pixel width constant (8), the default image size constants, the frame pixel count constant and the FSM state typedef in the shared package sobel_pkg.
REQ-031 SHALL implement the buffer as the sub-module sobel_px_fifo, a synchronous show-ahead FIFO with a fill count, instantiated once.

Verification
REQ-032 SHALL cover: IMG 4x4, src_ready_i=1, 16 pixels 0..15 back-to-back -> 16 transfers in order, sop on pixel 0, eop on pixel 15, one frame_done_o pulse, overflow_o=0.
REQ-033 SHALL cover: FIFO_DEPTH=4, src_ready_i=0, 6 pixels written -> fill_o=4, pixels 5 and 6 dropped, overflow_o=1; then src_ready_i=1 -> exactly 4 transfers.
REQ-034 SHALL cover: full buffer, simultaneous write and transfer -> fill_o stays 4, new pixel accepted, overflow_o stays 0.
REQ-035 SHALL cover: src_ready_i toggled 1/0 every cycle mid-frame -> src_data_o stable while stalled, no loss, sop/eop positions unchanged.
REQ-036 SHALL cover: rst_i asserted after 7 of 16 pixels -> all outputs at reset values; the next 16 pixels form a complete frame with sop on the first.
REQ-037 SHALL cover: with SOBEL_AVST_THRESHOLD_EN and THRESHOLD=128, inputs 127, 128, 255 -> outputs 8'h00, 8'hFF, 8'hFF.
